vdc_host: RTL and testbench

VDC_HOST -- requirements
Module: vdc_host

---
 rtl/vdc_host_if.sv | 24 ++
 rtl/vdc_host.sv | 147 ++++++++++++++
 tb/tb_vdc_host.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/vdc_host_if.sv
// Request/response channel between a host-side client and the VDC access sequencer.
// The client drives requests as master; vdc_host is the slave.
interface vdc_host_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [5:0] req_reg;
  logic [7:0] req_data;
  logic [7:0] req_count;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_last;
  logic       rsp_timeout;

  modport master (
    output req_valid, req_we, req_reg, req_data, req_count,
    input  req_ready, rsp_valid, rsp_data, rsp_last, rsp_timeout
  );

  modport slave (
    input  req_valid, req_we, req_reg, req_data, req_count,
    output req_ready, rsp_valid, rsp_data, rsp_last, rsp_timeout
  );
endinterface

// File: rtl/vdc_host.sv
// Sequences VDC register accesses: optional index write, status polling until ready,
// then one or more data accesses, with a response pulse per data access.
module vdc_host #(
  parameter int POLL_LIMIT = 1023,
  parameter bit SEL_CACHE  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enableBus,
  vdc_host_if.slave  bus,
  output logic       cs,
  output logic       rs,
  output logic       we,
  output logic [7:0] db_out,
  input  logic [7:0] db_in
);

  typedef enum logic [2:0] {
    IDLE, SEL, POLL, POLL_WAIT, DATA, DATA_WAIT, NEXT
  } state_t;

  // Last status read allowed before the access is forced through as a timeout.
  localparam logic [9:0] POLL_LAST = 10'(POLL_LIMIT - 1);

  state_t     state_q, state_d;
  logic       lat_we;
  logic [5:0] lat_reg;
  logic [7:0] lat_data;
  logic [7:0] lat_count;
  logic [5:0] sel_reg;
  logic       sel_valid;
  logic [9:0] poll_cnt;
  logic       to_flag;
  logic [7:0] rsp_data_q;
  logic       accept;
  logic       poll_expired;

  assign accept       = bus.req_valid && bus.req_ready;
  assign poll_expired = (poll_cnt == POLL_LAST);

  assign bus.req_ready   = (state_q == IDLE) && !reset;
  assign bus.rsp_valid   = (state_q == NEXT) && !reset;
  assign bus.rsp_last    = bus.rsp_valid && (lat_count == 8'd0);
  assign bus.rsp_timeout = bus.rsp_valid && to_flag;
  assign bus.rsp_data    = rsp_data_q;

  // NOTE: every output and next-state value gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cs      = 1'b0;
    rs      = 1'b0;
    we      = 1'b0;
    db_out  = 8'h00;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (SEL_CACHE && sel_valid && (bus.req_reg == sel_reg)) ? POLL : SEL;
        end
      end
      SEL: begin
        if (enableBus) begin
          cs      = 1'b1;
          we      = 1'b1;
          db_out  = {2'b00, lat_reg};
          state_d = POLL;
        end
      end
      POLL: begin
        if (enableBus) begin
          cs      = 1'b1;
          state_d = POLL_WAIT;
        end
      end
      POLL_WAIT: state_d = (db_in[7] || poll_expired) ? DATA : POLL;
      DATA: begin
        if (enableBus) begin
          cs      = 1'b1;
          rs      = 1'b1;
          we      = lat_we;
          db_out  = lat_we ? lat_data : 8'h00;
          state_d = DATA_WAIT;
        end
      end
      DATA_WAIT: state_d = NEXT;
      NEXT:      state_d = (lat_count == 8'd0) ? IDLE : POLL;
      default:   state_d = IDLE;
    endcase
    // The bus stays quiet during the reset cycle regardless of where the FSM was.
    if (reset) begin
      cs     = 1'b0;
      rs     = 1'b0;
      we     = 1'b0;
      db_out = 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lat_we     <= 1'b0;
      lat_reg    <= 6'd0;
      lat_data   <= 8'h00;
      lat_count  <= 8'd0;
      sel_reg    <= 6'd0;
      sel_valid  <= 1'b0;
      poll_cnt   <= 10'd0;
      to_flag    <= 1'b0;
      rsp_data_q <= 8'h00;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_we    <= bus.req_we;
            lat_reg   <= bus.req_reg;
            lat_data  <= bus.req_data;
            lat_count <= bus.req_count;
          end
        end
        SEL: begin
          if (enableBus) begin
            sel_reg   <= lat_reg;
            sel_valid <= 1'b1;
          end
        end
        POLL_WAIT: begin
          // Timeout is judged before incrementing, so the counter never passes POLL_LAST.
          if (!db_in[7]) begin
            if (poll_expired) to_flag  <= 1'b1;
            else              poll_cnt <= poll_cnt + 10'd1;
          end
        end
        DATA_WAIT: rsp_data_q <= lat_we ? 8'h00 : db_in;
        NEXT: begin
          poll_cnt <= 10'd0;
          to_flag  <= 1'b0;
          if (lat_count != 8'd0) lat_count <= lat_count - 8'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vdc_host.sv
// Self-checking bench for vdc_host: a scripted VDC model answers status/data reads, and a
// transaction-level model predicts the bus access list and response stream per request.
module tb_vdc_host;
  localparam int LIMIT = 4;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       enableBus = 1'b0;
  logic       cs, rs, we;
  logic [7:0] db_out;
  logic [7:0] db_in     = 8'h00;

  vdc_host_if bus();

  vdc_host #(.POLL_LIMIT(LIMIT), .SEL_CACHE(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .enableBus (enableBus),
    .bus       (bus),
    .cs        (cs),
    .rs        (rs),
    .we        (we),
    .db_out    (db_out),
    .db_in     (db_in)
  );

  always #5 clk = ~clk;

  // Bus-phase strobe toggles randomly, changed just after each rising edge.
  always begin
    @(posedge clk);
    #1 enableBus = ($urandom_range(0, 1) == 1);
  end

  int         vectors     = 0;
  int         miscompares = 0;
  logic [9:0] got_bus[$];   // {rs, we, db_out} per strobe
  logic [9:0] got_rsp[$];   // {rsp_data, rsp_last, rsp_timeout} per pulse
  logic [7:0] rd_vals[$];   // data the VDC returns for successive data reads
  int         rd_idx      = 0;
  int         poll_k      = 0;  // not-ready statuses before ready, per access
  int         polls_done  = 0;
  int         bad_strobe  = 0;
  int         bad_idle    = 0;
  bit         cache_v     = 1'b0;
  logic [5:0] cache_r     = 6'd0;

  // VDC model and bus/response recorder.
  always @(negedge clk) begin
    if (reset) polls_done <= 0;
    if (cs) begin
      got_bus.push_back({rs, we, db_out});
      if (!enableBus) bad_strobe <= bad_strobe + 1;
      if (!rs && !we) begin
        db_in      <= (polls_done < poll_k) ? {1'b0, 7'($urandom)} : {1'b1, 7'($urandom)};
        polls_done <= polls_done + 1;
      end else if (rs) begin
        polls_done <= 0;
        if (!we) begin
          db_in  <= (rd_idx < rd_vals.size()) ? rd_vals[rd_idx] : 8'h00;
          rd_idx <= rd_idx + 1;
        end
      end
    end else if (rs || we || db_out != 8'h00) begin
      bad_idle <= bad_idle + 1;
    end
    if (bus.rsp_valid) got_rsp.push_back({bus.rsp_data, bus.rsp_last, bus.rsp_timeout});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_req(input logic w, input logic [5:0] r, input logic [7:0] d,
                           input logic [7:0] cnt);
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = w;
    bus.req_reg   = r;
    bus.req_data  = d;
    bus.req_count = cnt;
    for (int c = 0; c < 100 && !bus.req_ready; c++) tick();
    check("req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_reg   = 6'($urandom);
    bus.req_data  = 8'($urandom);
    bus.req_count = 8'($urandom);
  endtask

  // k = not-ready statuses before ready per access; rdv >= 0 fixes the read value.
  task automatic run_req(input logic w, input logic [5:0] r, input logic [7:0] d,
                         input logic [7:0] cnt, input int k, input int rdv, input string tag);
    logic [9:0] eb[$];
    logic [9:0] er[$];
    int         bb, rb, np;
    logic [7:0] v;
    bb = got_bus.size();
    rb = got_rsp.size();
    if (!(cache_v && cache_r == r)) eb.push_back({2'b01, 2'b00, r});
    cache_v = 1'b1;
    cache_r = r;
    np = (k < LIMIT) ? k + 1 : LIMIT;
    for (int a = 0; a <= int'(cnt); a++) begin
      v = (rdv >= 0) ? 8'(rdv) : 8'($urandom);
      if (!w) rd_vals.push_back(v);
      for (int p = 0; p < np; p++) eb.push_back(10'h000);
      eb.push_back({1'b1, w, (w ? d : 8'h00)});
      er.push_back({(w ? 8'h00 : v), (a == int'(cnt)), (k >= LIMIT)});
    end
    poll_k = k;
    drive_req(w, r, d, cnt);
    for (int c = 0; c < 30000 && (got_rsp.size() - rb) < er.size(); c++) tick();
    repeat (4) tick();
    check({tag, ".rsp_count"}, got_rsp.size() - rb, er.size());
    check({tag, ".bus_count"}, got_bus.size() - bb, eb.size());
    for (int i = 0; i < er.size(); i++)
      if (rb + i < got_rsp.size()) check({tag, ".rsp"}, got_rsp[rb + i], er[i]);
    for (int i = 0; i < eb.size(); i++)
      if (bb + i < got_bus.size()) check({tag, ".bus"}, got_bus[bb + i], eb[i]);
    check({tag, ".cs_outside_enable"}, bad_strobe, 0);
    check({tag, ".idle_bus_nonzero"}, bad_idle, 0);
  endtask

  initial begin
    int bb, rb;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_reg   = 6'd0;
    bus.req_data  = 8'h00;
    bus.req_count = 8'd0;
    reset         = 1'b1;

    repeat (3) tick();
    check("rst.cs", cs, 0);
    check("rst.rs", rs, 0);
    check("rst.we", we, 0);
    check("rst.db_out", db_out, 0);
    check("rst.req_ready", bus.req_ready, 0);
    check("rst.rsp_valid", bus.rsp_valid, 0);
    check("rst.rsp_data", bus.rsp_data, 0);
    check("rst.rsp_last", bus.rsp_last, 0);
    check("rst.rsp_timeout", bus.rsp_timeout, 0);
    reset = 1'b0;
    #1 check("idle.req_ready", bus.req_ready, 1);

    run_req(1'b1, 6'd26, 8'hF0, 8'd0, 0, -1, "wr26_cold");
    run_req(1'b1, 6'd26, 8'hF0, 8'd0, 0, -1, "wr26_cached");
    run_req(1'b0, 6'd31, 8'h00, 8'd0, 3, 8'h5A, "rd31_poll3");
    run_req(1'b1, 6'd31, 8'h20, 8'd3, 0, -1, "wr31_x4");
    run_req(1'b0, 6'd5, 8'h00, 8'd0, 1000, -1, "rd5_timeout");
    run_req(1'b1, 6'd31, 8'h33, 8'd255, 1, -1, "wr31_x256");

    // Abort: reset lands while the FSM waits on the first status sample.
    bb = got_bus.size();
    rb = got_rsp.size();
    poll_k = 1000;
    drive_req(1'b1, 6'd7, 8'h11, 8'd0);
    for (int c = 0; c < 200 && got_bus.size() < bb + 2; c++) tick();
    check("abort.strobes_seen", got_bus.size() - bb, 2);
    @(negedge clk);
    #1 reset = 1'b1;
    tick();
    check("abort.req_ready_in_reset", bus.req_ready, 0);
    check("abort.cs_in_reset", cs, 0);
    reset = 1'b0;
    #1 check("abort.idle_after_reset", bus.req_ready, 1);
    repeat (3) tick();
    check("abort.no_rsp", got_rsp.size() - rb, 0);
    cache_v = 1'b0;
    run_req(1'b1, 6'd7, 8'h11, 8'd0, 0, -1, "after_abort_reselect");

    for (int n = 0; n < 12; n++)
      run_req(1'($urandom), 6'($urandom_range(28, 31)), 8'($urandom),
              8'($urandom_range(0, 3)), $urandom_range(0, 5), -1, "random");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
